// File: rtl/ws2812_frame_scheduler.sv
// Frame scheduler for a WS2812 RGB controller: fetches pixels from a frame
// buffer, hands them to the controller one at a time, then issues the latch (RESET) command.
module ws2812_frame_scheduler #(
  parameter int CLK_FREQ_KHZ = 10000,
  parameter int ADDR_W       = 8,
  parameter int LATCH_US     = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] pixel_count,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [23:0]       mem_rdata,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic [1:0]        command,
  input  logic              cmd_wait
);

  localparam int LATCH_RAW = CLK_FREQ_KHZ * LATCH_US / 1000;
  localparam int LATCH_CYC = (LATCH_RAW < 1) ? 1 : LATCH_RAW;
  localparam int LCNT_W    = $clog2(LATCH_CYC + 1);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_TX    = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PRESENT, S_TXWAIT, S_LATCH, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [ADDR_W-1:0] count, count_nxt;
  logic [LCNT_W-1:0] lcnt, lcnt_nxt;
  logic              drain, drain_nxt;
  logic [1:0]        cmd_nxt;
  logic [7:0]        r_nxt, g_nxt, b_nxt;
  logic [ADDR_W:0]   idx_inc;

  assign idx_inc  = {1'b0, idx} + {{ADDR_W{1'b0}}, 1'b1};
  assign mem_addr = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      count   <= '0;
      lcnt    <= '0;
      drain   <= 1'b0;
      command <= CMD_IDLE;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      count   <= count_nxt;
      lcnt    <= lcnt_nxt;
      drain   <= drain_nxt;
      command <= cmd_nxt;
      r       <= r_nxt;
      g       <= g_nxt;
      b       <= b_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    count_nxt  = count;
    lcnt_nxt   = lcnt;
    drain_nxt  = drain;
    cmd_nxt    = command;
    r_nxt      = r;
    g_nxt      = g;
    b_nxt      = b;
    mem_rd     = 1'b0;
    frame_done = 1'b0;
    busy       = (state != S_IDLE) && (state != S_DONE);

    case (state)
      S_IDLE: begin
        cmd_nxt = CMD_IDLE;
        if (start && (pixel_count != '0)) begin
          count_nxt = pixel_count;
          idx_nxt   = '0;
          drain_nxt = 1'b0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd    = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        {r_nxt, g_nxt, b_nxt} = mem_rdata;
        state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (cmd_wait) begin
          cmd_nxt   = CMD_TX;
          state_nxt = S_TXWAIT;
        end
      end
      S_TXWAIT: begin
        // drain: last pixel accepted, waiting for the controller to finish shifting it out
        if (!drain) begin
          if (!cmd_wait) begin
            if (idx_inc < {1'b0, count}) begin
              idx_nxt   = idx_inc[ADDR_W-1:0];
              state_nxt = S_FETCH;
            end else begin
              drain_nxt = 1'b1;
              cmd_nxt   = CMD_IDLE;
            end
          end
        end else if (cmd_wait) begin
          drain_nxt = 1'b0;
          cmd_nxt   = CMD_RESET;
          lcnt_nxt  = LCNT_W'(LATCH_CYC);
          state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        if (lcnt <= LCNT_W'(1)) begin
          lcnt_nxt  = '0;
          cmd_nxt   = CMD_IDLE;
          state_nxt = S_DONE;
        end else begin
          lcnt_nxt = lcnt - LCNT_W'(1);
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
